// File: rtl/div16by8_seq.sv
// Sequential restoring radix-2 divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Optional round-to-nearest quotient when DIV16BY8_ROUND_EN is defined.
module div16by8_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] O,
    input  logic [7:0]  B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  A,
    output logic [7:0]  R,
    output logic        OVF
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  rem, rem_nx;
    logic [7:0]  lo, lo_nx;
    logic [7:0]  q, q_nx;
    logic [7:0]  b_reg, b_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [7:0]  a_nx, r_nx;
    logic        ovf_nx;

    logic [8:0]  shifted;
    logic        q_bit;
    logic [7:0]  rem_step;
    logic [7:0]  q_step;

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);

    // Partial remainder stays below the divisor, so 8 bits hold it between steps.
    always_comb begin
        shifted  = {rem, lo[7]};
        q_bit    = (shifted >= {1'b0, b_reg});
        rem_step = q_bit ? (shifted[7:0] - b_reg) : shifted[7:0];
        q_step   = {q[6:0], q_bit};
    end

`ifdef DIV16BY8_ROUND_EN
    logic [8:0] rem_x2;
    logic       round_up;
    always_comb begin
        rem_x2   = {rem_step, 1'b0};
        round_up = (rem_x2 >= {1'b0, b_reg});
    end
`endif

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        lo_nx    = lo;
        q_nx     = q;
        b_nx     = b_reg;
        cnt_nx   = cnt;
        a_nx     = A;
        r_nx     = R;
        ovf_nx   = OVF;
        unique case (state)
            IDLE: begin
                if (IN_VALID) begin
                    b_nx = B;
                    if (O[15:8] >= B) begin
                        a_nx     = 8'hFF;
                        r_nx     = '0;
                        ovf_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        rem_nx   = O[15:8];
                        lo_nx    = O[7:0];
                        q_nx     = '0;
                        cnt_nx   = '0;
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                rem_nx = rem_step;
                lo_nx  = {lo[6:0], 1'b0};
                q_nx   = q_step;
                cnt_nx = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    r_nx   = rem_step;
                    a_nx   = q_step;
                    ovf_nx = 1'b0;
`ifdef DIV16BY8_ROUND_EN
                    if (round_up) begin
                        if (q_step == 8'hFF) begin
                            ovf_nx = 1'b1;
                        end else begin
                            a_nx = q_step + 8'd1;
                        end
                    end
`endif
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            rem   <= '0;
            lo    <= '0;
            q     <= '0;
            b_reg <= '0;
            cnt   <= '0;
            A     <= '0;
            R     <= '0;
            OVF   <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            lo    <= lo_nx;
            q     <= q_nx;
            b_reg <= b_nx;
            cnt   <= cnt_nx;
            A     <= a_nx;
            R     <= r_nx;
            OVF   <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_div16by8_seq.sv
// Directed scoreboard bench for div16by8_seq: expected results are queued at accept and checked at OUT_VALID.
module tb_div16by8_seq;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] O = '0;
    logic [7:0]  B = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [7:0]  A;
    logic [7:0]  R;
    logic        OVF;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] r;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    div16by8_seq dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .O         (O),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .A         (A),
        .R         (R),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] o, input logic [7:0] b);
        exp_t e;
        int   qq, rr;
        if (b == 8'd0 || int'(o[15:8]) >= int'(b)) begin
            e.a = 8'hFF; e.r = 8'h00; e.ovf = 1'b1; e.lat = 0;
        end else begin
            qq = int'(o) / int'(b);
            rr = int'(o) % int'(b);
            e.ovf = 1'b0;
            e.lat = 8;
`ifdef DIV16BY8_ROUND_EN
            if (2 * rr >= int'(b)) begin
                if (qq == 255) e.ovf = 1'b1;
                else qq = qq + 1;
            end
`endif
            e.a = qq[7:0];
            e.r = rr[7:0];
        end
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, IN_READY, 1);
        chk({tag, "_out_valid"}, OUT_VALID, 0);
        chk({tag, "_a"}, A, 0);
        chk({tag, "_r"}, R, 0);
        chk({tag, "_ovf"}, OVF, 0);
    endtask

    task automatic send(input logic [15:0] o, input logic [7:0] b);
        int n = 0;
        while (!IN_READY && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        chk("in_ready_wait", IN_READY, 1);
        @(negedge CLK);
        IN_VALID = 1'b1;
        O = o;
        B = b;
        sb.push_back(model(o, b));
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        O = 16'($urandom);
        B = 8'($urandom);
    endtask

    task automatic receive(input int hold, input bit poke);
        exp_t e;
        int   n = 0;
        logic [7:0] a0, r0;
        logic       v0;
        while (!OUT_VALID && n < 30) begin
            @(posedge CLK); #1; n++;
        end
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", n, e.lat);
            chk("out_valid", OUT_VALID, 1);
            chk("a", A, e.a);
            chk("r", R, e.r);
            chk("ovf", OVF, e.ovf);
        end
        chk("in_ready_busy", IN_READY, 0);
        a0 = A; r0 = R; v0 = OVF;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (poke) begin
                IN_VALID = ~IN_VALID;
                O = 16'($urandom);
                B = 8'($urandom);
            end
            @(posedge CLK); #1;
            chk("hold_valid", OUT_VALID, 1);
            chk("hold_in_ready", IN_READY, 0);
            chk("hold_a", A, a0);
            chk("hold_r", R, r0);
            chk("hold_ovf", OVF, v0);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        chk("handoff_valid", OUT_VALID, 0);
        chk("handoff_in_ready", IN_READY, 1);
        chk("handoff_a_kept", A, a0);
    endtask

    initial begin
        #1 RST_N = 1'b0;
        #3;
        check_reset_values("rst_low");
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check_reset_values("rst_idle");
        end

        send(16'h1234, 8'h56);  receive(0, 1'b0);
        send(16'd1000, 8'd7);   receive(0, 1'b0);
        send(16'h0500, 8'h05);  receive(0, 1'b0);
        send(16'h0001, 8'h00);  receive(0, 1'b0);
        send(16'd65025, 8'd255); receive(5, 1'b1);
        send(16'hFFFF, 8'hFF);  receive(1, 1'b0);
        send(16'h00FF, 8'h01);  receive(0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send(16'($urandom), 8'($urandom_range(1, 255)));
            receive(k % 3, 1'b0);
        end

        send(16'h1234, 8'h56);
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        sb.delete();
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            chk("post_rst_no_valid", OUT_VALID, 0);
        end
        send(16'd200, 8'd10);
        receive(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div16by8_seq.md
# div16by8_seq

Sequential unsigned divider, the inverse of the team's 8x8 multiplier library: it takes a 16-bit product-width operand `O` and an 8-bit divisor `B` and recovers the 8-bit quotient `A` and 8-bit remainder `R`. It uses a restoring radix-2 algorithm that resolves one quotient bit per cycle. Valid/ready handshakes on both sides let it sit behind a multiplier in the error-characterisation datapath, where it reconstructs operands from exact or approximate products.

## Interface
Parameters: none; widths are fixed at 16/8.

Ports:
- `CLK`  in  1  — single clock, rising edge.
- `RST_N`  in  1  — asynchronous active-low reset.
- `IN_VALID`  in  1  — operands valid.
- `IN_READY`  out  1  — block can accept operands.
- `O`  in  16  — dividend; sampled on the accept edge.
- `B`  in  8  — divisor; sampled on the accept edge.
- `OUT_VALID`  out  1  — result valid.
- `OUT_READY`  in  1  — consumer takes the result.
- `A`  out  8  — quotient.
- `R`  out  8  — remainder.
- `OVF`  out  1  — quotient does not fit in 8 bits, or `B`==0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `IN_READY`=1, `OUT_VALID`=0, `A`=0x00, `R`=0x00, `OVF`=0, internal counter=0.
- `IN_READY` = (state==IDLE). `OUT_VALID` = (state==DONE). Both are registered-state decodes with no combinational path from the inputs.
- Accept: IDLE and `IN_VALID`=1 on a rising edge. `O` and `B` are latched.
  - If `O[15:8]` >= `B`, which includes `B`==0: go to DONE with `A`=0xFF, `R`=0x00, `OVF`=1.
  - Otherwise: partial remainder (9 bits) = {0,`O[15:8]`}, low shift register = `O[7:0]`, counter=0, go to RUN.
- RUN, each edge:
  - trial = {rem[7:0], next dividend MSB} − {0,`B`}.
  - If non-negative: rem=trial and q bit=1; else the shifted rem is kept and q bit=0.
  - q shifts in at the LSB; counter increments.
  - After the 8th RUN edge (counter reaches 7 and wraps): load `A`=q, `R`=rem[7:0], `OVF`=0, go to DONE.
- DONE: outputs hold stable while `OUT_READY`=0. On an edge with `OUT_READY`=1, go to IDLE. `A`/`R`/`OVF` keep their last values until the next result loads.
- `IN_VALID` is ignored outside IDLE. `OUT_READY` is ignored outside DONE.
- Invariant for non-overflow results: `A`*`B`+`R` == `O` and `R` < `B`.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded and no `OUT_VALID` pulse follows reset release.

## Timing
- Accept on edge E0. A non-overflow result has `OUT_VALID`=1 after edge E8, a latency of 8 cycles.
- An overflow result has `OUT_VALID`=1 after edge E0, a latency of 1 cycle.
- If `OUT_READY`=1 on the first DONE edge, `IN_READY` is 1 after that edge. A new accept can happen one cycle later.
- Minimum initiation interval: 10 cycles (non-overflow), 2 cycles (overflow).
- No bypass: a result and a new accept never share a cycle.

## Configuration
- `DIV16BY8_ROUND_EN` defined:
  - When loading a non-overflow result, `A` = q+1 if 2·rem ≥ `B` (round to nearest, ties up); `R` still reports the truncating remainder.
  - If q==0xFF and rounding applies: `A`=0xFF, `OVF`=1.
  - Latency is unchanged; the rounding compare sits on the load path.
- Undefined: `A` is the truncated quotient and no rounding logic is present.

## Test plan
- Reset then idle: `IN_READY`=1, `OUT_VALID`=0, `A`=`R`=0, `OVF`=0 with `RST_N` low and for 3 cycles after release.
- `O`=0x1234, `B`=0x56: after 8 cycles `A`=0x36 (54), `R`=0x10, `OVF`=0. Rounding build gives the same `A`=54.
- `O`=1000, `B`=7: `A`=142, `R`=6. With `DIV16BY8_ROUND_EN`, `A`=143 and `R`=6.
- Overflow cases: `O`=0x0500, `B`=0x05, and `O`=0x0001, `B`=0x00. Each gives `OVF`=1, `A`=0xFF, `R`=0 on the cycle after accept.
- `O`=65025, `B`=255 with `OUT_READY` held low for 5 cycles:
  - `A`=255, `R`=0, `OVF`=0, all held stable.
  - `IN_READY` stays 0 and `IN_VALID` pulses are ignored until handoff.
- Pulse `RST_N` low 3 cycles after accepting `O`=0x1234, `B`=0x56: all outputs go to reset values and no `OUT_VALID` follows. A next op with `O`=200, `B`=10 yields `A`=20, `R`=0.
